// File: rtl/spm_pkg.sv
// Shared types and helpers for the serial-parallel multiplier.
package spm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } spm_state_e;

  // Cycles from operand handshake to the first cycle out_valid is high.
  function automatic int spm_lat(input int xw, input int yw);
    return xw + yw + 1;
  endfunction

endpackage

// File: rtl/spm_csa_cell.sv
// One carry-save cell of the SPM chain: full adder with registered sum and carry.
// sum_d is the combinational sum, used by cell 0 as the live product bit.
module spm_csa_cell #(
  parameter logic CLR_CARRY = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum_d,
  output logic sum_q,
  output logic carry_q
);

  logic carry_d;

  assign sum_d   = a ^ b ^ cin;
  assign carry_d = (a & b) | (a & cin) | (b & cin);

  // Sum/carry state; sync clear seeds the carry with CLR_CARRY at operand load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
    end else if (clr) begin
      sum_q   <= 1'b0;
      carry_q <= CLR_CARRY;
    end else if (en) begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/spm_seq_mult.sv
// Serial-parallel multiplier: x held parallel, y streamed LSB first through a
// chain of XW carry-save cells, one product bit per cycle, plus a parallel
// product register with valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// RUN   | XW+YW cycles, one product bit per cycle on p_bit
// DONE  | full product on p, out_valid high until out_ready
module spm_seq_mult
  import spm_pkg::*;
#(
  parameter int XW     = 8,
  parameter int YW     = 8,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XW-1:0]     x,
  input  logic [YW-1:0]     y,
  input  logic              abort,
  output logic              p_valid,
  output logic              p_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XW+YW-1:0]  p
);

  localparam int PW = XW + YW;
  localparam int CW = $clog2(PW + 1);
  localparam logic [CW-1:0] LAST = CW'(spm_lat(XW, YW) - 2);

  spm_state_e state, state_nxt;

  logic          accept;
  logic          run;
  logic          y_fill;
  logic [XW-1:0] x_q;
  logic [XW-1:0] pp;
  logic [XW-1:0] pp_eff;
  logic [XW-1:0] sum_d;
  logic [XW-1:0] sum_q;
  logic [XW-1:0] carry_q;
  logic [XW-1:0] sum_hi;
  logic [YW-1:0] y_sr;
  logic [CW-1:0] cnt;
  logic [PW-2:0] p_sh;

  assign accept = in_valid && in_ready;
  assign run    = (state == RUN);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; abort returns to IDLE from anywhere.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        if (abort)             state_nxt = IDLE;
        else if (cnt == LAST)  state_nxt = DONE;
      end
      DONE: if (abort || out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; abort masks in_ready so it always wins.
  always_comb begin
    in_ready  = (state == IDLE) && !abort;
    p_valid   = run;
    out_valid = (state == DONE);
    p_bit     = run & sum_d[0];
  end

  // Once y is exhausted the stream continues with its sign (or zero).
  assign y_fill = (SIGNED != 0) ? y_sr[YW-1] : 1'b0;

  // Operand capture, y serialisation and bit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q  <= '0;
      y_sr <= '0;
      cnt  <= '0;
    end else if (accept) begin
      x_q  <= x;
      y_sr <= y;
      cnt  <= '0;
    end else if (run) begin
      y_sr <= {y_fill, y_sr[YW-1:1]};
      cnt  <= cnt + CW'(1);
    end
  end

  assign pp = x_q & {XW{y_sr[0]}};

  // Signed mode: the MSB partial product carries negative weight. It is fed
  // inverted; the constant -2^(XW-1) per step that this introduces sums,
  // modulo 2^(XW+YW), to +2^(XW-1), supplied by seeding the MSB cell carry.
  always_comb begin
    pp_eff = pp;
    if (SIGNED != 0) pp_eff[XW-1] = ~pp[XW-1];
  end

  // Each cell adds its partial product to the shifted-down sum of its upper
  // neighbour and its own carry; cell 0's sum is the product bit.
  assign sum_hi = sum_q >> 1;

  for (genvar j = 0; j < XW; j++) begin : g_cell
    localparam logic CC = (SIGNED != 0) && (j == XW - 1);
    spm_csa_cell #(.CLR_CARRY(CC)) u_cell (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept),
      .en      (run),
      .a       (pp_eff[j]),
      .b       (sum_hi[j]),
      .cin     (carry_q[j]),
      .sum_d   (sum_d[j]),
      .sum_q   (sum_q[j]),
      .carry_q (carry_q[j])
    );
  end

  // Collect product bits; p updates only when a run completes unaborted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_sh <= '0;
      p    <= '0;
    end else if (run) begin
      p_sh <= {sum_d[0], p_sh[PW-2:1]};
      if ((cnt == LAST) && !abort) p <= {sum_d[0], p_sh};
    end
  end

endmodule
